// File: rtl/gpio_pkg.sv
// Shared definitions for the PicoBlaze GPIO bank: register offsets and address decode.
package gpio_pkg;

  localparam logic [2:0] GPIO_DATA = 3'd0;
  localparam logic [2:0] GPIO_DIR  = 3'd1;
  localparam logic [2:0] GPIO_PIN  = 3'd2;
  localparam logic [2:0] GPIO_POS  = 3'd3;
  localparam logic [2:0] GPIO_NEG  = 3'd4;
  localparam logic [2:0] GPIO_FLAG = 3'd5;
  localparam logic [2:0] GPIO_IE   = 3'd6;

  // A bank spans 8 aligned port addresses, so only the upper five bits select it.
  function automatic logic bank_hit(input logic [7:0] address, input logic [7:0] base);
    return address[7:3] == base[7:3];
  endfunction

endpackage

// File: rtl/gpio_filter.sv
// Per-pin input conditioning: synchroniser, optional debounce, and edge detection.
module gpio_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic filt,
  output logic rise_raw,
  output logic fall_raw
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   filt_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE == 0) begin : g_bypass
      always_ff @(posedge clk) begin
        if (rst) filt <= 1'b0;
        else     filt <= sync;
      end
    end else begin : g_debounce
      logic [7:0] cnt_q;

      // filt follows sync only after DEBOUNCE consecutive disagreeing cycles.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
          filt  <= 1'b0;
        end else if (sync == filt) begin
          cnt_q <= '0;
        end else if (cnt_q == 8'(DEBOUNCE)) begin
          cnt_q <= '0;
          filt  <= sync;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) filt_d <= 1'b0;
    else     filt_d <= filt;
  end

  assign rise_raw = filt & ~filt_d;
  assign fall_raw = ~filt & filt_d;

endmodule

// File: rtl/gpio_bank.sv
// PicoBlaze GPIO bank: register file, interrupt-on-change flags, read mux and interrupt.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'h00,
  parameter int         WIDTH       = 8,
  parameter int         SYNC_STAGES = 2,
  parameter int         DEBOUNCE    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       address,
  input  logic [7:0]       value_in,
  input  logic             wen,
  input  logic             ren,
  output logic [7:0]       port_out,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic             int_out
);

  logic [WIDTH-1:0] data_q, dir_q, pos_q, neg_q, flag_q, ie_q;
  logic [WIDTH-1:0] filt, rise_raw, fall_raw;
  logic [WIDTH-1:0] wdata, w1c, ioc_edge;
  logic [2:0]       offset;
  logic             hit, wr_en;
  logic [7:0]       rdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
    ) u_filter (
      .clk     (clk),
      .rst     (rst),
      .pad     (pad_in[i]),
      .filt    (filt[i]),
      .rise_raw(rise_raw[i]),
      .fall_raw(fall_raw[i])
    );
  end

  assign hit      = bank_hit(address, BASE_ADDR);
  assign offset   = address[2:0];
  assign wr_en    = wen & hit;
  assign wdata    = value_in[WIDTH-1:0];
  assign w1c      = (wr_en && offset == GPIO_FLAG) ? wdata : '0;
  assign ioc_edge = (rise_raw & pos_q) | (fall_raw & neg_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      dir_q  <= '0;
      pos_q  <= '0;
      neg_q  <= '0;
      ie_q   <= '0;
    end else if (wr_en) begin
      case (offset)
        GPIO_DATA: data_q <= wdata;
        GPIO_DIR:  dir_q  <= wdata;
        GPIO_POS:  pos_q  <= wdata;
        GPIO_NEG:  neg_q  <= wdata;
        GPIO_IE:   ie_q   <= wdata;
        default:   ;
      endcase
    end
  end

  // Clear is applied before the set so a same-cycle edge keeps the flag high.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q  <= '0;
      int_out <= 1'b0;
    end else begin
      flag_q  <= (flag_q & ~w1c) | ioc_edge;
      int_out <= |(flag_q & ie_q);
    end
  end

  // NOTE: rdata is given a default before the case so no latch is inferred.
  always_comb begin
    rdata = 8'h00;
    case (offset)
      GPIO_DATA: rdata = 8'(data_q);
      GPIO_DIR:  rdata = 8'(dir_q);
      GPIO_PIN:  rdata = 8'(filt);
      GPIO_POS:  rdata = 8'(pos_q);
      GPIO_NEG:  rdata = 8'(neg_q);
      GPIO_FLAG: rdata = 8'(flag_q);
      GPIO_IE:   rdata = 8'(ie_q);
      default:   rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      port_out <= 8'h00;
    else if (ren) port_out <= hit ? rdata : 8'h00;
  end

  assign pad_out = data_q;
  assign pad_oe  = dir_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: two banks (DEBOUNCE 0 and 4) on a shared port bus.
module tb_gpio_bank;

  localparam logic [7:0] BASE = 8'h10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] address = 8'h00;
  logic [7:0] value_in = 8'h00;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  logic [4:0] pad0 = '0, pad4 = '0;
  logic [7:0] port_out0, port_out4;
  logic [4:0] pad_out0, pad_out4, pad_oe0, pad_oe4;
  logic       int0, int4;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
    bit         sel;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  gpio_bank #(.BASE_ADDR(BASE), .WIDTH(5), .SYNC_STAGES(2), .DEBOUNCE(0)) u_dut0 (
    .clk(clk), .rst(rst), .address(address), .value_in(value_in), .wen(wen), .ren(ren),
    .port_out(port_out0), .pad_in(pad0), .pad_out(pad_out0), .pad_oe(pad_oe0), .int_out(int0)
  );

  gpio_bank #(.BASE_ADDR(BASE), .WIDTH(5), .SYNC_STAGES(2), .DEBOUNCE(4)) u_dut4 (
    .clk(clk), .rst(rst), .address(address), .value_in(value_in), .wen(wen), .ren(ren),
    .port_out(port_out4), .pad_in(pad4), .pad_out(pad_out4), .pad_oe(pad_oe4), .int_out(int4)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 8'h%02h expected 8'h%02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] off, input logic [7:0] d);
    address  = BASE + off;
    value_in = d;
    wen      = 1'b1;
    tick();
    wen      = 1'b0;
  endtask

  // Expected read data is queued at issue and retired when port_out updates.
  task automatic rd(input logic [7:0] off, input logic [7:0] val, input bit sel, input string t);
    exp_t e;
    exp_q.push_back('{tag: t, val: val, sel: sel});
    address = BASE + off;
    ren     = 1'b1;
    tick();
    ren     = 1'b0;
    e = exp_q.pop_front();
    check(e.tag, e.sel ? port_out4 : port_out0, e.val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick(2);
    rst = 1'b0;
    check("rst_pad_oe", 8'(pad_oe0), 8'h00);
    check("rst_pad_out", 8'(pad_out0), 8'h00);
    check("rst_int", 8'(int0), 8'h00);
    for (int i = 0; i < 8; i++) rd(8'(i), 8'h00, 1'b0, $sformatf("rst_rd_%0d", i));

    // Write / readback, WIDTH=5
    wr(8'd0, 8'hFF);
    wr(8'd1, 8'h0F);
    check("pad_out", 8'(pad_out0), 8'h1F);
    check("pad_oe", 8'(pad_oe0), 8'h0F);
    rd(8'd0, 8'h1F, 1'b0, "rd_data");
    address = BASE + 8'd1;
    tick();
    check("port_out_hold", port_out0, 8'h1F);
    rd(8'd1, 8'h0F, 1'b0, "rd_dir");
    wr(8'd2, 8'hFF);
    wr(8'd7, 8'hFF);
    rd(8'd2, 8'h00, 1'b0, "rd_pin_ro");
    rd(8'd7, 8'h00, 1'b0, "rd_rsvd");
    rd(8'd9, 8'h00, 1'b0, "rd_out_of_bank");

    // Rising IOC, DEBOUNCE=0: flag at N+3, int at N+4
    wr(8'd3, 8'h01);
    wr(8'd6, 8'h01);
    pad0[0] = 1'b1;
    tick(3);
    rd(8'd5, 8'h00, 1'b0, "flag_before_n3");
    check("int_at_n3", 8'(int0), 8'h00);
    rd(8'd5, 8'h01, 1'b0, "flag_after_n3");
    check("int_at_n4", 8'(int0), 8'h01);
    rd(8'd2, 8'h01, 1'b0, "pin0_high");
    wr(8'd5, 8'h01);
    check("int_w1c_edge1", 8'(int0), 8'h01);
    tick();
    check("int_w1c_edge2", 8'(int0), 8'h00);
    rd(8'd5, 8'h00, 1'b0, "flag_cleared");

    // Same-cycle falling edge and W1C on bit 1
    wr(8'd3, 8'h03);
    wr(8'd4, 8'h02);
    wr(8'd6, 8'h03);
    pad0[1] = 1'b1;
    tick(5);
    check("int_bit1_rise", 8'(int0), 8'h01);
    rd(8'd5, 8'h02, 1'b0, "flag_bit1_rise");
    pad0[1] = 1'b0;
    tick(3);
    wr(8'd5, 8'h02);
    check("int_collide_e1", 8'(int0), 8'h01);
    tick();
    check("int_collide_e2", 8'(int0), 8'h01);
    rd(8'd5, 8'h02, 1'b0, "flag_edge_wins");
    wr(8'd5, 8'h02);
    tick();
    check("int_bit1_clear", 8'(int0), 8'h00);

    // Masked NEG edge, then enable IE
    wr(8'd6, 8'h00);
    wr(8'd4, 8'h01);
    pad0[0] = 1'b0;
    tick(6);
    check("int_masked", 8'(int0), 8'h00);
    rd(8'd5, 8'h01, 1'b0, "flag_masked_set");
    wr(8'd6, 8'h01);
    check("int_ie_write_edge", 8'(int0), 8'h00);
    tick();
    check("int_ie_next_edge", 8'(int0), 8'h01);
    wr(8'd5, 8'hFF);

    // Debounce=4: short glitch rejected, level accepted 4 edges late
    wr(8'd3, 8'h04);
    wr(8'd4, 8'h00);
    wr(8'd6, 8'h04);
    pad4[2] = 1'b1;
    tick(3);
    pad4[2] = 1'b0;
    tick(10);
    rd(8'd2, 8'h00, 1'b1, "db_glitch_pin");
    rd(8'd5, 8'h00, 1'b1, "db_glitch_flag");
    check("db_glitch_int", 8'(int4), 8'h00);
    pad4[2] = 1'b1;
    tick(6);
    pad4[2] = 1'b0;
    tick();
    rd(8'd5, 8'h00, 1'b1, "db_flag_before_n7");
    check("db_int_at_n7", 8'(int4), 8'h00);
    rd(8'd5, 8'h04, 1'b1, "db_flag_after_n7");
    check("db_int_at_n8", 8'(int4), 8'h01);
    rd(8'd2, 8'h04, 1'b1, "db_pin_high");
    tick(10);
    rd(8'd2, 8'h00, 1'b1, "db_pin_low");

    // Reset during a debounce count
    rd(8'd0, 8'h1F, 1'b1, "pre_rst_data");
    pad4[2] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_port_out", port_out4, 8'h00);
    check("mid_rst_int", 8'(int4), 8'h00);
    check("mid_rst_pad_oe", 8'(pad_oe4), 8'h00);
    tick(6);
    rd(8'd2, 8'h00, 1'b1, "post_rst_pin_n6");
    rd(8'd2, 8'h04, 1'b1, "post_rst_pin_n7");
    rd(8'd5, 8'h00, 1'b1, "post_rst_no_flag");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
